dispatch_stage: RTL and testbench
=================================

Name: dispatch_stage

Overview:
- Parametrised N-wide in-order dispatch stage between Register Rename and the per-pipe Reservation Stations (Wakeup/Select).
- Buffers renamed uops in one unified circular queue. Assigns each accepted uop a ROB index on enqueue, in program order.
- Each cycle, issues up to DISP_WIDTH oldest uops to their target execution pipes. Per-pipe collision limits and RS free counts are enforced. Supports full flush.

Parameters:
- DISP_WIDTH, 2, rename/dispatch lanes per cycle (1..4)
- NUM_PIPES, 4, execution pipes, each with its own RS
- QUEUE_DEPTH, 8, queue entries; power of 2, >= 2*DISP_WIDTH
- UOP_W, 64, uop payload width
- ROB_IDX_W, 6, ROB index width; wraps modulo 2^ROB_IDX_W
- RS_CNT_W, 4, width of each RS free-count input
- PIPE_W, $clog2(NUM_PIPES), pipe-select width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all queued and incoming uops
- stall  in  1  global backend stall; blocks dispatch only
- in_valid  in  DISP_WIDTH  rename lane valid; must be contiguous from lane 0
- in_uop  in  DISP_WIDTH*UOP_W  renamed uop per lane
- in_pipe  in  DISP_WIDTH*PIPE_W  target pipe per lane
- in_ready  out  1  queue free >= DISP_WIDTH and rob_free_cnt >= DISP_WIDTH
- rob_tail_idx  in  ROB_IDX_W  ROB index for lane 0 this cycle
- rob_free_cnt  in  ROB_IDX_W+1  free ROB entries
- rob_alloc  out  DISP_WIDTH  per-lane ROB allocate strobe
- rs_free_cnt  in  NUM_PIPES*RS_CNT_W  free RS entries per pipe
- out_valid  out  DISP_WIDTH  dispatch slot k fires
- out_uop  out  DISP_WIDTH*UOP_W  dispatched uop
- out_pipe  out  DISP_WIDTH*PIPE_W  target pipe
- out_rob_idx  out  DISP_WIDTH*ROB_IDX_W  ROB index of the dispatched uop
- occupancy  out  $clog2(QUEUE_DEPTH)+1  valid queue entries

Behaviour:
- Reset, synchronous active-high on rst with clock clk: head = tail = 0, occupancy = 0. out_valid, rob_alloc = 0; in_ready = 1 one cycle after reset deasserts.
- Enqueue: lane i accepted iff in_ready & in_valid[i] & ~flush. rob_alloc[i] equals this (combinational).
  - Entry stores {uop, pipe, rob_tail_idx+i mod 2^ROB_IDX_W}. Written at tail+i; tail advances by the popcount of accepted lanes.
  - Lanes valid above a gap are ignored: no alloc, no write.
- Dispatch is combinational from registered queue state plus stall/rs_free_cnt. Slot k reads entry head+k. Slot k fires iff all of the following hold:
  - ~stall and ~flush;
  - k < occupancy;
  - slots 0..k-1 fired (strict in-order, stop at first block);
  - no earlier firing slot this cycle targets the same pipe (1 RS write port per pipe);
  - rs_free_cnt[pipe] != 0.
  - head advances by the number fired. Latency: enqueue at cycle t, earliest dispatch at t+1; no rename-to-dispatch bypass.
- Simultaneous enqueue and dispatch is allowed in the same cycle; occupancy_next = occupancy + enq - deq.
- in_ready is computed from registered occupancy only, with no credit for same-cycle dispatch.
- Pointers are log2(QUEUE_DEPTH) wide and wrap naturally; full/empty are derived from occupancy, never from pointer equality.
- Flush: out_valid = 0 and rob_alloc = 0 that cycle; next cycle head = tail = 0, occupancy = 0. Flush has priority over stall, enqueue and dispatch.
- Stall freezes dispatch only; enqueue continues until in_ready drops.
- No uop is ever dropped or reordered; out_rob_idx is strictly increasing (mod wrap) across cycles.

Decomposition:
- CORE_PKG: DISP_WIDTH, NUM_PIPES, ROB_IDX_W; dispatch queue entry struct {uop, pipe, rob_idx}; pipe index typedef.
- Sub-module dispatch_queue: multi-write/multi-read circular buffer with DISP_WIDTH write ports (contiguous from tail) and DISP_WIDTH read ports (head+k). Inputs are write count and read count; it owns head/tail/occupancy.
- dispatch_stage holds ROB index assignment, enqueue gating and the fire/collision logic.

Test Plan:
- Reset, then 2 lanes valid, pipes {0,1}, rob_tail_idx=5, rs_free all 3 -> cycle t: rob_alloc=11. Cycle t+1: out_valid=11, out_rob_idx={5,6}, occupancy returns to 0.
- Both lanes target pipe 2, rs_free[2]=4 -> slot0 fires, slot1 blocked. Next cycle the remaining uop fires in slot0; order preserved.
- Head targets pipe 3 with rs_free[3]=0 and entry 1 targets pipe 0 (free) -> out_valid=00 (no bypass of older uop). Set rs_free[3]=1 -> out_valid=11 if pipes differ.
- stall=1 with continuous 2-wide enqueue, QUEUE_DEPTH=8 -> occupancy 2,4,6, then in_ready=0 at 6 (free 2 is still ok? no: free=2, in_ready=1), then 8 -> in_ready=0 and no rob_alloc. Release stall -> drains in order with wrap past entry 7.
- rob_free_cnt=1, 2 lanes valid -> in_ready=0, rob_alloc=00.
- rob_tail_idx=63, ROB_IDX_W=6 -> indices {63,0}.
- occupancy=5 plus flush with lanes valid -> rob_alloc=00 and out_valid=00. Next cycle occupancy=0, in_ready=1, and no stale uop ever appears on out_valid.

Source files
------------

// File: rtl/dispatch_stage_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_stage_pkg
//   Shared constants and types for the rename -> reservation-station dispatch
//   slice. The localparams are the default configuration of dispatch_stage;
//   the entry layout below matches that default and is what neighbouring
//   blocks (and the bench model) use to talk about a queued uop.
// -----------------------------------------------------------------------------
package dispatch_stage_pkg;

  localparam int DISP_WIDTH  = 2;   // rename/dispatch lanes per cycle
  localparam int NUM_PIPES   = 4;   // execution pipes, one RS each
  localparam int QUEUE_DEPTH = 8;   // unified dispatch queue entries
  localparam int UOP_W       = 64;  // uop payload width
  localparam int ROB_IDX_W   = 6;   // ROB index width, wraps naturally
  localparam int RS_CNT_W    = 4;   // width of each RS free count
  localparam int PIPE_W      = $clog2(NUM_PIPES);

  typedef logic [PIPE_W-1:0]    pipe_idx_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  // One queued uop: payload, target pipe and the ROB slot it was given.
  typedef struct packed {
    logic [UOP_W-1:0] uop;
    pipe_idx_t        pipe;
    rob_idx_t         rob_idx;
  } disp_entry_t;

endpackage

// File: rtl/dispatch_stage_queue.sv
// -----------------------------------------------------------------------------
// dispatch_queue
//   Circular buffer with LANES write ports (tail+i) and LANES read ports
//   (head+k). The caller supplies how many lanes to write and how many read
//   slots were consumed; the queue owns head, tail and occupancy. Full and
//   empty are judged from occupancy only, so pointers simply wrap.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   flush_i      empty the queue (pointers and count back to zero)
//   wr_cnt_i     number of entries written this cycle, from lane 0 upward
//   wr_data_i    write data per lane
//   rd_cnt_i     number of entries consumed this cycle, from slot 0 upward
//   rd_data_o    entry at head+k for each read slot (unqualified)
//   occupancy_o  number of valid entries
// -----------------------------------------------------------------------------
module dispatch_queue #(
  parameter  int LANES   = 2,
  parameter  int DEPTH   = 8,
  parameter  int ENTRY_W = 72,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1,
  localparam int LCNT_W  = $clog2(LANES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [LCNT_W-1:0]              wr_cnt_i,
  input  logic [LANES-1:0][ENTRY_W-1:0]  wr_data_i,
  input  logic [LCNT_W-1:0]              rd_cnt_i,
  output logic [LANES-1:0][ENTRY_W-1:0]  rd_data_o,
  output logic [CNT_W-1:0]               occupancy_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   occ_q,  occ_d;

  // NOTE: every combinational output gets a default first, so no path through the block can infer a latch.
  always_comb begin
    head_d = head_q + PTR_W'(rd_cnt_i);
    tail_d = tail_q + PTR_W'(wr_cnt_i);
    occ_d  = occ_q + CNT_W'(wr_cnt_i) - CNT_W'(rd_cnt_i);
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (LCNT_W'(i) < wr_cnt_i) begin
        mem_q[tail_q + PTR_W'(i)] <= wr_data_i[i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rd_data_o[k] = mem_q[head_q + PTR_W'(k)];
    end
  end

  assign occupancy_o = occ_q;

endmodule

// File: rtl/dispatch_stage.sv
// -----------------------------------------------------------------------------
// dispatch_stage
//   N-wide in-order dispatch between rename and the per-pipe reservation
//   stations. Accepted uops get consecutive ROB indices starting at
//   rob_tail_idx and are queued; each cycle up to DISP_WIDTH of the oldest
//   uops are sent to their pipes, stopping at the first one that cannot go
//   (stall, flush, empty slot, pipe already used this cycle, or RS full).
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   flush          drop everything queued and arriving this cycle
//   stall          hold dispatch; enqueue keeps going while in_ready
//   in_valid/uop/pipe   rename lanes (valid contiguous from lane 0)
//   in_ready       room for a full rename group in queue and ROB
//   rob_tail_idx   ROB index for lane 0; rob_free_cnt free ROB entries
//   rob_alloc      per-lane ROB allocate strobe (lane accepted)
//   rs_free_cnt    free RS entries per pipe
//   out_valid/uop/pipe/rob_idx   dispatch slots
//   occupancy      valid queue entries
// -----------------------------------------------------------------------------
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int DISP_WIDTH  = dispatch_stage_pkg::DISP_WIDTH,
  parameter int NUM_PIPES   = dispatch_stage_pkg::NUM_PIPES,
  parameter int QUEUE_DEPTH = dispatch_stage_pkg::QUEUE_DEPTH,
  parameter int UOP_W       = dispatch_stage_pkg::UOP_W,
  parameter int ROB_IDX_W   = dispatch_stage_pkg::ROB_IDX_W,
  parameter int RS_CNT_W    = dispatch_stage_pkg::RS_CNT_W,
  parameter int PIPE_W      = $clog2(NUM_PIPES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            stall,
  input  logic [DISP_WIDTH-1:0]           in_valid,
  input  logic [DISP_WIDTH*UOP_W-1:0]     in_uop,
  input  logic [DISP_WIDTH*PIPE_W-1:0]    in_pipe,
  output logic                            in_ready,
  input  logic [ROB_IDX_W-1:0]            rob_tail_idx,
  input  logic [ROB_IDX_W:0]              rob_free_cnt,
  output logic [DISP_WIDTH-1:0]           rob_alloc,
  input  logic [NUM_PIPES*RS_CNT_W-1:0]   rs_free_cnt,
  output logic [DISP_WIDTH-1:0]           out_valid,
  output logic [DISP_WIDTH*UOP_W-1:0]     out_uop,
  output logic [DISP_WIDTH*PIPE_W-1:0]    out_pipe,
  output logic [DISP_WIDTH*ROB_IDX_W-1:0] out_rob_idx,
  output logic [$clog2(QUEUE_DEPTH):0]    occupancy
);

  localparam int QPTR_W  = $clog2(QUEUE_DEPTH);
  localparam int OCC_W   = QPTR_W + 1;
  localparam int LCNT_W  = $clog2(DISP_WIDTH + 1);
  localparam int ROBC_W  = ROB_IDX_W + 1;
  localparam int ENTRY_W = UOP_W + PIPE_W + ROB_IDX_W;

  typedef struct packed {
    logic [UOP_W-1:0]     uop;
    logic [PIPE_W-1:0]    pipe;
    logic [ROB_IDX_W-1:0] rob_idx;
  } entry_t;

  entry_t [DISP_WIDTH-1:0] wr_entry;
  entry_t [DISP_WIDTH-1:0] rd_entry;
  logic   [LCNT_W-1:0]     wr_cnt;
  logic   [LCNT_W-1:0]     rd_cnt;
  logic   [OCC_W-1:0]      occ;
  logic   [DISP_WIDTH-1:0] accept;
  logic   [DISP_WIDTH-1:0] fire;
  logic                    room_ok;
  logic                    rob_ok;

  dispatch_queue #(
    .LANES   (DISP_WIDTH),
    .DEPTH   (QUEUE_DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .wr_cnt_i    (wr_cnt),
    .wr_data_i   (wr_entry),
    .rd_cnt_i    (rd_cnt),
    .rd_data_o   (rd_entry),
    .occupancy_o (occ)
  );

  // Readiness looks only at the registered count: a whole rename group must
  // fit without counting on anything leaving this cycle.
  assign room_ok  = (OCC_W'(QUEUE_DEPTH) - occ) >= OCC_W'(DISP_WIDTH);
  assign rob_ok   = rob_free_cnt >= ROBC_W'(DISP_WIDTH);
  assign in_ready = ~rst & room_ok & rob_ok;

  // Enqueue: a lane is taken only while every lane below it is valid, so a
  // valid lane sitting above a gap is ignored. Accepted lanes are therefore
  // always contiguous from lane 0 and a simple count drives the queue.
  always_comb begin : enqueue_logic
    logic run;
    accept = '0;
    wr_cnt = '0;
    run    = in_ready & ~flush;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      run       = run & in_valid[i];
      accept[i] = run;
      if (run) begin
        wr_cnt = wr_cnt + LCNT_W'(1);
      end
      wr_entry[i].uop     = in_uop[i*UOP_W +: UOP_W];
      wr_entry[i].pipe    = in_pipe[i*PIPE_W +: PIPE_W];
      wr_entry[i].rob_idx = rob_tail_idx + ROB_IDX_W'(i);
    end
  end

  assign rob_alloc = accept;

  // Dispatch: strictly in order from head. Once a slot is blocked nothing
  // younger may go; each pipe has one RS write port, so a pipe already used
  // by an earlier slot this cycle blocks the later slot too.
  always_comb begin : fire_logic
    logic                 go;
    logic [NUM_PIPES-1:0] used;
    logic [RS_CNT_W-1:0]  free_sel;
    fire   = '0;
    rd_cnt = '0;
    used   = '0;
    go     = ~rst & ~stall & ~flush;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      free_sel = '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (rd_entry[k].pipe == PIPE_W'(p)) begin
          free_sel = rs_free_cnt[p*RS_CNT_W +: RS_CNT_W];
        end
      end
      if (OCC_W'(k) >= occ)          go = 1'b0;
      if (used[rd_entry[k].pipe])    go = 1'b0;
      if (free_sel == '0)            go = 1'b0;
      fire[k] = go;
      if (go) begin
        used[rd_entry[k].pipe] = 1'b1;
        rd_cnt = rd_cnt + LCNT_W'(1);
      end
    end
  end

  always_comb begin
    out_uop     = '0;
    out_pipe    = '0;
    out_rob_idx = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      out_uop[k*UOP_W +: UOP_W]             = rd_entry[k].uop;
      out_pipe[k*PIPE_W +: PIPE_W]          = rd_entry[k].pipe;
      out_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] = rd_entry[k].rob_idx;
    end
  end

  assign out_valid = fire;
  assign occupancy = occ;

endmodule

// File: tb/tb_dispatch_stage.sv
// -----------------------------------------------------------------------------
// tb_dispatch_stage
//   Directed scenarios for the dispatch stage followed by a randomized run
//   checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_dispatch_stage;
  import dispatch_stage_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            flush;
  logic                            stall;
  logic [DISP_WIDTH-1:0]           in_valid;
  logic [DISP_WIDTH*UOP_W-1:0]     in_uop;
  logic [DISP_WIDTH*PIPE_W-1:0]    in_pipe;
  logic                            in_ready;
  logic [ROB_IDX_W-1:0]            rob_tail_idx;
  logic [ROB_IDX_W:0]              rob_free_cnt;
  logic [DISP_WIDTH-1:0]           rob_alloc;
  logic [NUM_PIPES*RS_CNT_W-1:0]   rs_free_cnt;
  logic [DISP_WIDTH-1:0]           out_valid;
  logic [DISP_WIDTH*UOP_W-1:0]     out_uop;
  logic [DISP_WIDTH*PIPE_W-1:0]    out_pipe;
  logic [DISP_WIDTH*ROB_IDX_W-1:0] out_rob_idx;
  logic [$clog2(QUEUE_DEPTH):0]    occupancy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dispatch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .stall        (stall),
    .in_valid     (in_valid),
    .in_uop       (in_uop),
    .in_pipe      (in_pipe),
    .in_ready     (in_ready),
    .rob_tail_idx (rob_tail_idx),
    .rob_free_cnt (rob_free_cnt),
    .rob_alloc    (rob_alloc),
    .rs_free_cnt  (rs_free_cnt),
    .out_valid    (out_valid),
    .out_uop      (out_uop),
    .out_pipe     (out_pipe),
    .out_rob_idx  (out_rob_idx),
    .occupancy    (occupancy)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled a
  // further unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    stall        = 1'b0;
    in_valid     = '0;
    in_uop       = '0;
    in_pipe      = '0;
    rob_tail_idx = '0;
    rob_free_cnt = 7'd64;
    rs_free_cnt  = 16'h3333;
  endtask

  task automatic set_lane(input int i, input logic [UOP_W-1:0] u, input logic [PIPE_W-1:0] p);
    in_uop[i*UOP_W +: UOP_W]    = u;
    in_pipe[i*PIPE_W +: PIPE_W] = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    in_valid = 2'b11;
    #1;
    n_total++; if (rob_alloc !== 2'b00) $display("FAIL reset_alloc_in_rst: got %b want 00", rob_alloc); else n_pass++;
    n_total++; if (out_valid !== 2'b00) $display("FAIL reset_outvalid_in_rst: got %b want 00", out_valid); else n_pass++;
    in_valid = 2'b00;
    rst = 1'b0;
    tick();
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (occupancy !== 4'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else n_pass++;
    n_total++; if (out_valid !== 2'b00) $display("FAIL reset_outvalid: got %b want 00", out_valid); else n_pass++;
    n_total++; if (rob_alloc !== 2'b00) $display("FAIL reset_alloc: got %b want 00", rob_alloc); else n_pass++;
  endtask

  task automatic test_basic();
    idle();
    set_lane(0, 64'hA0, 2'd0);
    set_lane(1, 64'hA1, 2'd1);
    rob_tail_idx = 6'd5;
    in_valid     = 2'b11;
    #1;
    n_total++; if (rob_alloc !== 2'b11) $display("FAIL basic_alloc: got %b want 11", rob_alloc); else n_pass++;
    n_total++; if (out_valid !== 2'b00) $display("FAIL basic_no_bypass: got %b want 00", out_valid); else n_pass++;
    tick();
    in_valid = 2'b00;
    #1;
    n_total++; if (out_valid !== 2'b11) $display("FAIL basic_valid: got %b want 11", out_valid); else n_pass++;
    n_total++; if (out_rob_idx !== {6'd6, 6'd5}) $display("FAIL basic_rob: got %h want %h", out_rob_idx, {6'd6, 6'd5}); else n_pass++;
    n_total++; if (out_uop !== {64'hA1, 64'hA0}) $display("FAIL basic_uop: got %h", out_uop); else n_pass++;
    n_total++; if (out_pipe !== 4'b0100) $display("FAIL basic_pipe: got %b want 0100", out_pipe); else n_pass++;
    tick();
    #1;
    n_total++; if (occupancy !== 4'd0) $display("FAIL basic_occ: got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_collision();
    idle();
    rs_free_cnt = 16'h3433;
    set_lane(0, 64'hB0, 2'd2);
    set_lane(1, 64'hB1, 2'd2);
    rob_tail_idx = 6'd10;
    in_valid     = 2'b11;
    tick();
    in_valid = 2'b00;
    #1;
    n_total++; if (out_valid !== 2'b01) $display("FAIL coll_first: got %b want 01", out_valid); else n_pass++;
    n_total++; if (out_rob_idx[5:0] !== 6'd10) $display("FAIL coll_first_rob: got %0d want 10", out_rob_idx[5:0]); else n_pass++;
    tick();
    #1;
    n_total++; if (out_valid !== 2'b01) $display("FAIL coll_second: got %b want 01", out_valid); else n_pass++;
    n_total++; if (out_uop[63:0] !== 64'hB1) $display("FAIL coll_second_uop: got %h want b1", out_uop[63:0]); else n_pass++;
    n_total++; if (out_rob_idx[5:0] !== 6'd11) $display("FAIL coll_second_rob: got %0d want 11", out_rob_idx[5:0]); else n_pass++;
    tick();
    #1;
    n_total++; if (occupancy !== 4'd0) $display("FAIL coll_occ: got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_no_bypass();
    idle();
    rs_free_cnt = 16'h0333;
    set_lane(0, 64'hC0, 2'd3);
    set_lane(1, 64'hC1, 2'd0);
    rob_tail_idx = 6'd20;
    in_valid     = 2'b11;
    tick();
    in_valid = 2'b00;
    #1;
    n_total++; if (out_valid !== 2'b00) $display("FAIL nobyp_blocked: got %b want 00", out_valid); else n_pass++;
    tick();
    #1;
    n_total++; if (out_valid !== 2'b00) $display("FAIL nobyp_held: got %b want 00", out_valid); else n_pass++;
    n_total++; if (occupancy !== 4'd2) $display("FAIL nobyp_occ: got %0d want 2", occupancy); else n_pass++;
    rs_free_cnt = 16'h1333;
    #1;
    n_total++; if (out_valid !== 2'b11) $display("FAIL nobyp_release: got %b want 11", out_valid); else n_pass++;
    n_total++; if (out_rob_idx !== {6'd21, 6'd20}) $display("FAIL nobyp_rob: got %h", out_rob_idx); else n_pass++;
    tick();
    #1;
    n_total++; if (occupancy !== 4'd0) $display("FAIL nobyp_occ_end: got %0d want 0", occupancy); else n_pass++;
  endtask

  // Fill to full under stall, then drain across the pointer wrap.
  task automatic test_stall_fill();
    logic [5:0] rob;
    idle();
    stall = 1'b1;
    rob   = 6'd30;
    for (int j = 0; j <= 4; j++) begin
      set_lane(0, 64'h1000 + 64'(rob), 2'd0);
      set_lane(1, 64'h1000 + 64'(rob + 6'd1), 2'd1);
      rob_tail_idx = rob;
      in_valid     = 2'b11;
      #1;
      n_total++; if (occupancy !== 4'(2 * j)) $display("FAIL fill_occ_%0d: got %0d want %0d", j, occupancy, 2 * j); else n_pass++;
      n_total++; if (in_ready !== (j < 4)) $display("FAIL fill_ready_%0d: got %b want %b", j, in_ready, j < 4); else n_pass++;
      n_total++; if (rob_alloc !== ((j < 4) ? 2'b11 : 2'b00)) $display("FAIL fill_alloc_%0d: got %b", j, rob_alloc); else n_pass++;
      n_total++; if (out_valid !== 2'b00) $display("FAIL fill_stalled_%0d: got %b want 00", j, out_valid); else n_pass++;
      if (j < 4) rob = rob + 6'd2;
      tick();
    end
    in_valid = 2'b00;
    stall    = 1'b0;
    for (int m = 0; m < 4; m++) begin
      logic [5:0] r0;
      r0 = 6'd30 + 6'(2 * m);
      #1;
      n_total++; if (out_valid !== 2'b11) $display("FAIL drain_valid_%0d: got %b want 11", m, out_valid); else n_pass++;
      n_total++; if (out_rob_idx !== {r0 + 6'd1, r0}) $display("FAIL drain_rob_%0d: got %h want %h", m, out_rob_idx, {r0 + 6'd1, r0}); else n_pass++;
      n_total++; if (out_uop !== {64'h1000 + 64'(r0 + 6'd1), 64'h1000 + 64'(r0)}) $display("FAIL drain_uop_%0d: got %h", m, out_uop); else n_pass++;
      tick();
    end
    #1;
    n_total++; if (occupancy !== 4'd0) $display("FAIL drain_occ: got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_rob_credit();
    idle();
    set_lane(0, 64'hE0, 2'd0);
    set_lane(1, 64'hE1, 2'd1);
    rob_free_cnt = 7'd1;
    in_valid     = 2'b11;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL robcred_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (rob_alloc !== 2'b00) $display("FAIL robcred_alloc: got %b want 00", rob_alloc); else n_pass++;
    rob_free_cnt = 7'd2;
    #1;
    n_total++; if (rob_alloc !== 2'b11) $display("FAIL robcred_edge_alloc: got %b want 11", rob_alloc); else n_pass++;
    in_valid = 2'b00;
    tick();
    #1;
    n_total++; if (occupancy !== 4'd0) $display("FAIL robcred_occ: got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_gap();
    idle();
    set_lane(1, 64'hF1, 2'd1);
    in_valid = 2'b10;
    #1;
    n_total++; if (rob_alloc !== 2'b00) $display("FAIL gap_alloc: got %b want 00", rob_alloc); else n_pass++;
    tick();
    in_valid = 2'b00;
    #1;
    n_total++; if (occupancy !== 4'd0) $display("FAIL gap_occ: got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_rob_wrap();
    idle();
    set_lane(0, 64'h77, 2'd0);
    set_lane(1, 64'h78, 2'd1);
    rob_tail_idx = 6'd63;
    in_valid     = 2'b11;
    tick();
    in_valid = 2'b00;
    #1;
    n_total++; if (out_valid !== 2'b11) $display("FAIL wrap_valid: got %b want 11", out_valid); else n_pass++;
    n_total++; if (out_rob_idx !== {6'd0, 6'd63}) $display("FAIL wrap_rob: got %h want %h", out_rob_idx, {6'd0, 6'd63}); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    idle();
    stall = 1'b1;
    set_lane(0, 64'hD0, 2'd0);
    set_lane(1, 64'hD1, 2'd1);
    in_valid = 2'b11;
    tick();
    tick();
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    #1;
    n_total++; if (occupancy !== 4'd5) $display("FAIL flush_pre_occ: got %0d want 5", occupancy); else n_pass++;
    flush    = 1'b1;
    stall    = 1'b0;
    in_valid = 2'b11;
    #1;
    n_total++; if (rob_alloc !== 2'b00) $display("FAIL flush_alloc: got %b want 00", rob_alloc); else n_pass++;
    n_total++; if (out_valid !== 2'b00) $display("FAIL flush_valid: got %b want 00", out_valid); else n_pass++;
    tick();
    flush    = 1'b0;
    in_valid = 2'b00;
    #1;
    n_total++; if (occupancy !== 4'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 2'b00) $display("FAIL flush_stale: got %b want 00", out_valid); else n_pass++;
    set_lane(0, 64'hF00D, 2'd2);
    rob_tail_idx = 6'd40;
    in_valid     = 2'b01;
    tick();
    in_valid = 2'b00;
    #1;
    n_total++; if (out_valid !== 2'b01) $display("FAIL flush_fresh_valid: got %b want 01", out_valid); else n_pass++;
    n_total++; if (out_uop[63:0] !== 64'hF00D || out_rob_idx[5:0] !== 6'd40) $display("FAIL flush_fresh_entry: got uop %h rob %0d want f00d 40", out_uop[63:0], out_rob_idx[5:0]); else n_pass++;
    tick();
  endtask

  // Randomized traffic against a queue model: readiness, allocation and the
  // in-order fire rule are recomputed from the queue contents each cycle.
  task automatic test_random();
    disp_entry_t q[$];
    logic [ROB_IDX_W-1:0] rob_ctr;
    rob_ctr = '0;
    idle();
    for (int c = 0; c < 800; c++) begin
      bit                   exp_ready;
      logic [1:0]           exp_alloc;
      logic [1:0]           exp_valid;
      int                   n_fire;
      int                   n_acc;
      logic [NUM_PIPES-1:0] used;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       in_valid = 2'b00;
        1:       in_valid = 2'b01;
        2:       in_valid = 2'b10;
        default: in_valid = 2'b11;
      endcase
      for (int i = 0; i < DISP_WIDTH; i++) begin
        set_lane(i, {$urandom, $urandom}, PIPE_W'($urandom_range(0, NUM_PIPES - 1)));
      end
      rob_tail_idx = rob_ctr;
      rob_free_cnt = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 2)) : 7'd64;
      for (int p = 0; p < NUM_PIPES; p++) begin
        rs_free_cnt[p*RS_CNT_W +: RS_CNT_W] = RS_CNT_W'($urandom_range(0, 3));
      end
      #1;
      exp_ready    = (QUEUE_DEPTH - q.size() >= DISP_WIDTH) && (rob_free_cnt >= 7'(DISP_WIDTH));
      exp_alloc[0] = exp_ready && !flush && in_valid[0];
      exp_alloc[1] = exp_alloc[0] && in_valid[1];
      n_fire = 0;
      used   = '0;
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (flush || stall || k >= q.size()) break;
        if (used[q[k].pipe] || rs_free_cnt[q[k].pipe*RS_CNT_W +: RS_CNT_W] == '0) break;
        used[q[k].pipe] = 1'b1;
        n_fire++;
      end
      exp_valid = (n_fire == 0) ? 2'b00 : (n_fire == 1) ? 2'b01 : 2'b11;
      n_total++; if (in_ready !== exp_ready) $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, exp_ready); else n_pass++;
      n_total++; if (rob_alloc !== exp_alloc) $display("FAIL rnd_alloc c%0d: got %b want %b", c, rob_alloc, exp_alloc); else n_pass++;
      n_total++; if (occupancy !== 4'(q.size())) $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occupancy, q.size()); else n_pass++;
      n_total++; if (out_valid !== exp_valid) $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, exp_valid); else n_pass++;
      for (int k = 0; k < n_fire; k++) begin
        disp_entry_t got;
        got.uop     = out_uop[k*UOP_W +: UOP_W];
        got.pipe    = out_pipe[k*PIPE_W +: PIPE_W];
        got.rob_idx = out_rob_idx[k*ROB_IDX_W +: ROB_IDX_W];
        n_total++; if (got !== q[k]) $display("FAIL rnd_entry c%0d s%0d: got %h want %h", c, k, got, q[k]); else n_pass++;
      end
      tick();
      if (flush) begin
        q.delete();
      end else begin
        for (int k = 0; k < n_fire; k++) void'(q.pop_front());
        n_acc = 0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
          if (exp_alloc[i]) begin
            disp_entry_t e;
            e.uop     = in_uop[i*UOP_W +: UOP_W];
            e.pipe    = in_pipe[i*PIPE_W +: PIPE_W];
            e.rob_idx = rob_tail_idx + ROB_IDX_W'(i);
            q.push_back(e);
            n_acc++;
          end
        end
        rob_ctr = rob_ctr + ROB_IDX_W'(n_acc);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_no_bypass();
    test_stall_fill();
    test_rob_credit();
    test_gap();
    test_rob_wrap();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
